// File: rtl/dmem_responder_if.sv
// Request/response bus of the data-memory responder.
// master = load/store unit side, slave = memory side.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic        req_byte_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_yumi_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  // Request: a transfer happens on a rising edge where req_valid_i and
  // req_ready_o are both high. Response: resp_valid_o stays high with stable
  // data until a rising edge that sees resp_yumi_i high.
  modport master (
    output req_valid_i, req_we_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory for LW/LBU/SW/SB with a three-state FSM.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned word accesses with resp_err_o.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  we_q;
  logic                  byte_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [4:0]            lane_bit;
  logic                  misaligned;
  logic                  do_write;
  logic [31:0]           cur_word;
  logic [31:0]           merged_word;
  logic [31:0]           load_data;

  // Upper address bits are dropped on capture, so the array aliases.
  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign lane     = addr_q[1:0];
  assign lane_bit = {lane, 3'b000};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = !byte_q && (lane != 2'd0);
`else
  assign misaligned = 1'b0;
`endif

  assign do_write = (state_q == ACCESS) && we_q && !misaligned && !reset;

  always_comb begin
    cur_word    = mem[idx];
    merged_word = wdata_q;
    load_data   = cur_word;
    if (byte_q) begin
      merged_word                = cur_word;
      merged_word[lane_bit +: 8] = wdata_q[7:0];
      load_data                  = {24'h0, cur_word[lane_bit +: 8]};
    end
    if (we_q || misaligned) begin
      load_data = 32'h0;
    end
  end

  // No reset on the array: contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid_i) begin
        we_q    <= bus.req_we_i;
        byte_q  <= bus.req_byte_i;
        addr_q  <= bus.req_addr_i[DEPTH_LOG2+1:0];
        wdata_q <= bus.req_wdata_i;
      end
      if (state_q == ACCESS) begin
        rdata_q <= load_data;
        err_q   <= misaligned;
      end
    end
  end

  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic        err;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    valid   = 1'b0;
    rdata   = 32'h0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid_i) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        valid = 1'b1;
        rdata = rdata_q;
        err   = err_q;
        if (bus.resp_yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = valid;
  assign bus.resp_rdata_o = rdata;
  assign bus.resp_err_o   = err;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed literal cases plus random
// traffic compared every cycle against a behavioural memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_LOG2(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  logic [31:0] mdl_mem [0:1023];
  logic [32:0] exp_q[$];
  int phase = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural reference: returns {err, rdata} and applies stores.
  function automatic logic [32:0] model_access(logic we, logic byt, logic [31:0] addr,
                                               logic [31:0] wdata);
    logic [9:0]  idx;
    logic [1:0]  lane;
    logic [31:0] w;
    bit          bad;
    idx  = addr[11:2];
    lane = addr[1:0];
    bad  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = !byt && (lane != 2'd0);
`endif
    if (bad) return {1'b1, 32'h0};
    w = mdl_mem[idx];
    if (we) begin
      if (byt) w[8*lane +: 8] = wdata[7:0];
      else     w = wdata;
      mdl_mem[idx] = w;
      return 33'h0;
    end
    if (byt) return {1'b0, 24'h0, w[8*lane +: 8]};
    return {1'b0, w};
  endfunction

  // Transaction-level progress: 0 idle, 1 request in flight, 2 response shown.
  always @(posedge clk) begin
    if (reset) begin
      phase = 0;
      exp_q.delete();
    end else begin
      case (phase)
        0: if (bus.req_valid_i) begin
             exp_q.push_back(model_access(bus.req_we_i, bus.req_byte_i,
                                          bus.req_addr_i, bus.req_wdata_i));
             phase = 1;
           end
        1: phase = 2;
        default: if (bus.resp_yumi_i) begin
             void'(exp_q.pop_front());
             phase = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [32:0] exp_resp;
    if (run) begin
      exp_resp = 33'h0;
      if (phase == 2 && exp_q.size() > 0) exp_resp = exp_q[0];
      chk("req_ready",  {31'h0, bus.req_ready_o},  {31'h0, phase == 0});
      chk("resp_valid", {31'h0, bus.resp_valid_o}, {31'h0, phase == 2});
      chk("resp_rdata", bus.resp_rdata_o, exp_resp[31:0]);
      chk("resp_err",   {31'h0, bus.resp_err_o},   {31'h0, exp_resp[32]});
    end
  end

  task automatic xact(input logic we, input logic byt, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, input bit rst_in_resp,
                      output logic [31:0] rd, output logic err);
    bit ok;
    int lat;
    rd  = 32'hx;
    err = 1'bx;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_byte_i  = byt;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'h0, 32'h1);
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin ok = 1'b1; lat = i; break; end
    end
    if (!ok) begin
      chk("resp_timeout", 32'h0, 32'h1);
      return;
    end
    chk("latency", lat, 32'd1);
    rd  = bus.resp_rdata_o;
    err = bus.resp_err_o;
    // Competing requests while the response is held must not be taken.
    repeat (hold) begin
      @(posedge clk); #1;
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_byte_i  = 1'b0;
      bus.req_addr_i  = $urandom;
      bus.req_wdata_i = $urandom;
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (rst_in_resp) reset = 1'b1;
    else             bus.resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_yumi_i = 1'b0;
    reset           = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    reset           = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_byte_i  = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.resp_yumi_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 run = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready_o},  32'h1);
    chk("rst_valid", {31'h0, bus.resp_valid_o}, 32'h0);
    chk("rst_rdata", bus.resp_rdata_o, 32'h0);
    chk("rst_err",   {31'h0, bus.resp_err_o},   32'h0);
    @(posedge clk); #1 reset = 1'b0;

    xact(1, 0, 32'h10, 32'hDEADBEEF, 0, 0, rd, er);
    chk("sw_rdata", rd, 32'h0);
    xact(0, 0, 32'h10, 32'h0, 0, 0, rd, er);
    chk("lw_10", rd, 32'hDEADBEEF);
    chk("lw_10_err", {31'h0, er}, 32'h0);
    xact(1, 1, 32'h12, 32'h55, 0, 0, rd, er);
    xact(0, 0, 32'h10, 32'h0, 0, 0, rd, er);
    chk("lw_after_sb", rd, 32'hDE55BEEF);
    xact(0, 1, 32'h13, 32'h0, 0, 0, rd, er);
    chk("lbu_13", rd, 32'h000000DE);
    xact(0, 0, 32'h10, 32'h0, 5, 0, rd, er);
    chk("lw_hold", rd, 32'hDE55BEEF);
    xact(1, 0, 32'h1000, 32'h1, 0, 0, rd, er);
    xact(0, 0, 32'h0, 32'h0, 0, 0, rd, er);
    chk("lw_alias", rd, 32'h00000001);
    xact(1, 0, 32'h20, 32'hCAFEF00D, 0, 0, rd, er);
    xact(1, 0, 32'h21, 32'h12345678, 0, 0, rd, er);
    xact(0, 0, 32'h20, 32'h0, 0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("lw_20_after_bad_sw", rd, 32'hCAFEF00D);
`else
    chk("lw_20_after_bad_sw", rd, 32'h12345678);
`endif
    xact(0, 0, 32'h10, 32'h0, 1, 1, rd, er);
    xact(0, 0, 32'h10, 32'h0, 0, 0, rd, er);
    chk("lw_after_reset", rd, 32'hDE55BEEF);

    for (int i = 0; i < 16; i++) begin
      xact(1, 0, i * 4, $urandom, 0, 0, rd, er);
    end
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      xact($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom,
           $urandom_range(0, 3), $urandom_range(0, 19) == 0, rd, er);
    end

    @(negedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, number of 32-bit words as log2 (1024 words).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1, load/store request present.
REQ-005 SHALL have port req_ready_o, output, 1, request accepted when high with req_valid_i.
REQ-006 SHALL have port req_we_i, input, 1, 1 = store (SW/SB), 0 = load (LW/LBU).
REQ-007 SHALL have port req_byte_i, input, 1, 1 = byte access (LBU/SB), 0 = word access (LW/SW).
REQ-008 SHALL have port req_addr_i, input, 32, byte address from the ALU result.
REQ-009 SHALL have port req_wdata_i, input, 32, store data; SB uses bits 7:0.
REQ-010 SHALL have port resp_valid_o, output, 1, response available.
REQ-011 SHALL have port resp_yumi_i, input, 1, consumer takes response this cycle.
REQ-012 SHALL have port resp_rdata_o, output, 32, load data; 0 for stores.
REQ-013 SHALL have port resp_err_o, output, 1, misaligned-access flag (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-015 IDLE: req_ready_o=1; req_valid_i high captures we, byte, addr, wdata and moves to ACCESS.
REQ-016 ACCESS: req_ready_o=0; performs array read/write; always moves to RESP next cycle.
REQ-017 RESP: resp_valid_o=1, outputs held stable until resp_yumi_i; yumi -> IDLE next cycle.
REQ-018 resp_yumi_i outside RESP SHALL be ignored; req_valid_i outside IDLE SHALL be ignored (not accepted).
REQ-019 Latency: request accepted at edge N; resp_valid_o high from cycle N+2; at most one outstanding request.
REQ-020 Word index SHALL be req_addr_i[DEPTH_LOG2+1:2]; higher address bits ignored (wrap-around aliasing).
REQ-021 Byte lane SHALL be req_addr_i[1:0], little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
REQ-022 LW SHALL return the full word; LBU SHALL return the selected lane zero-extended to 32 bits.
REQ-023 SW SHALL write all 32 bits; SB SHALL write only the selected lane, other lanes unchanged.
REQ-024 Stores SHALL still produce one response with resp_rdata_o=0.
REQ-025 A load directly after a store to the same word SHALL return the stored value.
REQ-026 resp_rdata_o and resp_err_o SHALL be 0 whenever resp_valid_o is 0.

Reset
REQ-027 reset SHALL force IDLE; req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0 the next cycle.
REQ-028 reset mid-operation SHALL discard any pending response; a write performed in ACCESS before reset stays committed.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL take priority over req_valid_i and resp_yumi_i in the same cycle.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: word access with req_addr_i[1:0]!=0 SHALL not write, SHALL return resp_rdata_o=0 and resp_err_o=1; byte accesses never flag.
REQ-032 Macro DMEM_ALIGN_CHECK_EN undefined: req_addr_i[1:0] ignored for word accesses, resp_err_o tied 0, port retained.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata_o=0xDEADBEEF, resp_err_o=0, resp_valid_o at N+2.
REQ-034 After REQ-033, SB addr 0x12 data 0x55, LW 0x10 -> 0xDE55BEEF; LBU 0x13 -> 0x000000DE.
REQ-035 Hold resp_yumi_i=0 five cycles in RESP -> resp_valid_o and data stable, req_ready_o=0, new req_valid_i not accepted.
REQ-036 DEPTH_LOG2=10: SW addr 0x1000 data 0x1 then LW addr 0x0 -> 0x00000001 (wrap aliasing).
REQ-037 reset asserted in RESP -> next cycle resp_valid_o=0, req_ready_o=1; subsequent LW of stored word returns pre-reset data.
REQ-038 With DMEM_ALIGN_CHECK_EN: SW addr 0x21 -> resp_err_o=1, rdata 0; LW 0x20 unchanged. Without: SW 0x21 writes word 0x20, resp_err_o=0.
